set_assoc_tag_ram: RTL
======================

# set_assoc_tag_ram

Parametrised N-way set-associative tag/payload store. It serves as the next-generation lookup array behind the sv32 MMU TLB and small caches in the kianv multicycle core. Lookups are combinational and writes are registered. A victim is chosen per set when all ways are valid, and a sequential flush engine walks every set to invalidate it for `sfence.vma`/`fence.i` without a wide single-cycle clear.

## Interface
- `SET_ADDR_WIDTH`, 4: set index width; SETS = 2**SET_ADDR_WIDTH.
- `WAYS`, 4: associativity; power of two, 2..8.
- `TAG_WIDTH`, 20: tag width.
- `PAYLOAD_WIDTH`, 32: payload width.

Ports:
- `clk` in 1: sole clock.
- `resetn` in 1: asynchronous, active-low reset.
- `idx` in SET_ADDR_WIDTH: set index.
- `tag` in TAG_WIDTH: compare/write tag.
- `payload_i` in PAYLOAD_WIDTH: write data.
- `valid_i` in 1: request qualifier.
- `we` in 1: write when `valid_i`.
- `flush_i` in 1: start invalidate-all.
- `hit_o` out 1: tag matched a valid way.
- `hit_way_o` out log2(WAYS): matching way, 0 on miss.
- `payload_o` out PAYLOAD_WIDTH: matching payload, 0 on miss.
- `busy_o` out 1: flush in progress.

## Operation
- **Lookup (combinational):**
  - All ways of set `idx` are compared against `tag`, qualified by their valid bits.
  - At most one way can match, because writes never create duplicates.
  - `hit_o`, `hit_way_o` and `payload_o` are forced to 0 while `busy_o` is high.
- **Write (`valid_i && we && !busy_o`)**, in priority order:
  1. If `tag` hits, overwrite that way's payload only.
  2. Else, if any way is invalid, fill the lowest-numbered invalid way.
  3. Else, replace the victim way.
  - The written way's tag, payload and valid bit are updated at the next edge.
- **Replacement state:** one record per set.
  - It is updated on every write.
  - It is also updated on every read hit (`valid_i && !we && hit_o`); see Configuration for what each build records.
- **FSM states:** IDLE, FLUSH.
  - IDLE -> FLUSH: on `flush_i` high at an edge. The set counter is loaded with 0.
  - In FLUSH, each cycle clears the valid bits and replacement state of set[counter], then increments the counter.
  - FLUSH -> IDLE: after set SETS-1 is cleared.
  - `busy_o` = (state == FLUSH).
- **Boundary conditions:**
  - `flush_i` while busy is ignored; the flush does not restart.
  - `flush_i` together with a write in IDLE: flush wins and the write is dropped.
  - Writes and read-hit replacement updates during FLUSH are dropped.
  - Tags and payloads are never cleared; only valid bits and replacement state are.
- **Reset (asynchronous, immediate, including mid-flush):**
  - All valid bits, all replacement state and the counter are cleared; FSM goes to IDLE.
  - Outputs: `hit_o`=0, `hit_way_o`=0, `payload_o`=0, `busy_o`=0.

## Timing
- Lookup latency is 0 cycles; outputs follow `idx`/`tag` combinationally.
- A write is visible to lookups in the cycle after its edge.
- Read-after-write to the same set in the same cycle returns the old contents.
- Flush sampled at edge T:
  - `busy_o` is high from T through T+SETS, i.e. for exactly SETS cycles.
  - It is low again after edge T+SETS.
  - A new `flush_i` is accepted at that same edge.
- Victim selection uses the replacement state registered before the current edge.

## Configuration
- `TAG_RAM_PLRU_EN` defined: tree pseudo-LRU, WAYS-1 bits per set.
  - Tree layout: bit 0 is the root; the children of bit k are 2k+1 and 2k+2.
  - Victim walk: a bit value of 0 selects the lower half.
  - On any access (hit or write) to way w, each bit on w's path is set to point away from w.
  - Reset/flush value is all zeros.
- Undefined: per-set round-robin pointer of log2(WAYS) bits, reset 0.
  - The victim is the pointer value.
  - The pointer increments modulo WAYS only on a victim replacement.
  - Hits and fills of invalid ways leave the pointer unchanged.
- The interface is identical in both builds.

## Test plan
All scenarios use WAYS=4 and SET_ADDR_WIDTH=4.
1. Reset, then look up `idx`=3, `tag`=0x12345 -> `hit_o`=0, `payload_o`=0, `busy_o`=0.
2. Write tags 0xA/0xB/0xC/0xD to set 3 with payloads 1/2/3/4 -> lookups hit in ways 0/1/2/3 with the matching payloads; the same tags in set 4 miss.
3. After scenario 2, read tag 0xA, then write tag 0xE with payload 5:
   - PLRU build: way 2 is replaced, so 0xC misses.
   - Round-robin build: way 0 is replaced, so 0xA misses.
4. Rewrite tag 0xB in set 3 with payload 0x99 -> way 1 returns 0x99; the other three ways are unchanged; there is no duplicate entry.
5. Pulse `flush_i` -> `busy_o` is high exactly 16 cycles; a lookup of 0xA during the flush misses; a write of 0xF during the flush is dropped; after the flush every earlier tag misses.
6. Assert `resetn` low at flush cycle 5 -> `busy_o` drops to 0 immediately without a clock edge; after release all lookups miss and a new flush takes 16 cycles.

Source files
------------

// File: rtl/set_assoc_tag_ram_if.sv
// Request/response bundle for set_assoc_tag_ram.
// master: requester side (drives idx/tag/payload_i/valid_i/we/flush_i).
// slave : tag RAM side (drives hit_o/hit_way_o/payload_o/busy_o).
interface set_assoc_tag_ram_if #(
   parameter int unsigned SET_ADDR_WIDTH = 4,
   parameter int unsigned WAYS           = 4,
   parameter int unsigned TAG_WIDTH      = 20,
   parameter int unsigned PAYLOAD_WIDTH  = 32
) ();
   localparam int unsigned WAY_W = $clog2(WAYS);

   logic [SET_ADDR_WIDTH-1:0] idx;
   logic [TAG_WIDTH-1:0]      tag;
   logic [PAYLOAD_WIDTH-1:0]  payload_i;
   logic                      valid_i;
   logic                      we;
   logic                      flush_i;
   logic                      hit_o;
   logic [WAY_W-1:0]          hit_way_o;
   logic [PAYLOAD_WIDTH-1:0]  payload_o;
   logic                      busy_o;

   modport master (
      output idx, tag, payload_i, valid_i, we, flush_i,
      input  hit_o, hit_way_o, payload_o, busy_o
   );

   modport slave (
      input  idx, tag, payload_i, valid_i, we, flush_i,
      output hit_o, hit_way_o, payload_o, busy_o
   );
endinterface

// File: rtl/set_assoc_tag_ram.sv
// N-way set-associative tag/payload store with combinational lookup,
// registered writes, per-set victim selection and a sequential flush engine.
// Ports: clk, resetn (async active-low), bus (set_assoc_tag_ram_if.slave):
//   idx/tag/payload_i/valid_i/we/flush_i in; hit_o/hit_way_o/payload_o/busy_o out.
// Build option: TAG_RAM_PLRU_EN selects tree pseudo-LRU replacement;
// otherwise a per-set round-robin pointer is used.
module set_assoc_tag_ram #(
   parameter int unsigned SET_ADDR_WIDTH = 4,
   parameter int unsigned WAYS           = 4,
   parameter int unsigned TAG_WIDTH      = 20,
   parameter int unsigned PAYLOAD_WIDTH  = 32
) (
   input logic                clk,
   input logic                resetn,
   set_assoc_tag_ram_if.slave bus
);
   localparam int unsigned SETS   = 2**SET_ADDR_WIDTH;
   localparam int unsigned WAY_W  = $clog2(WAYS);
   localparam int unsigned PLRU_W = WAYS - 1;

   typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_e;

   state_e                    state_q, state_d;
   logic [SET_ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                      busy_c;
   logic                      clr_c;

   logic [TAG_WIDTH-1:0]     tag_mem [SETS][WAYS];
   logic [PAYLOAD_WIDTH-1:0] pay_mem [SETS][WAYS];
   logic [WAYS-1:0]          valid_q [SETS];

   logic             raw_hit_c;
   logic [WAY_W-1:0] raw_way_c;
   logic             hit_c;
   logic             free_any_c;
   logic [WAY_W-1:0] free_way_c;
   logic [WAY_W-1:0] victim_c;
   logic [WAY_W-1:0] wr_way_c;
   logic             wr_en_c;

   // FSM state register and flush set counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state; a flush request on the final flush edge restarts it
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.flush_i) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end
         end
         FLUSH: begin
            cnt_d = cnt_q + SET_ADDR_WIDTH'(1);
            if (cnt_q == SET_ADDR_WIDTH'(SETS - 1)) begin
               state_d = bus.flush_i ? FLUSH : IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM outputs
   always_comb begin
      busy_c = 1'b0;
      clr_c  = 1'b0;
      if (state_q == FLUSH) begin
         busy_c = 1'b1;
         clr_c  = 1'b1;
      end
   end

   // Tag compare across all ways of the addressed set
   always_comb begin
      raw_hit_c = 1'b0;
      raw_way_c = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_q[bus.idx][w] && (tag_mem[bus.idx][w] == bus.tag)) begin
            raw_hit_c = 1'b1;
            raw_way_c = WAY_W'(w);
         end
      end
   end

   // Lowest-numbered invalid way (descending scan so the lowest wins)
   always_comb begin
      free_any_c = 1'b0;
      free_way_c = '0;
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (!valid_q[bus.idx][w]) begin
            free_any_c = 1'b1;
            free_way_c = WAY_W'(w);
         end
      end
   end

   assign hit_c         = raw_hit_c && !busy_c;
   assign bus.hit_o     = hit_c;
   assign bus.hit_way_o = hit_c ? raw_way_c : '0;
   assign bus.payload_o = hit_c ? pay_mem[bus.idx][raw_way_c] : '0;
   assign bus.busy_o    = busy_c;

   // Flush request in IDLE takes precedence over a same-cycle write
   assign wr_en_c  = bus.valid_i && bus.we && !busy_c && !bus.flush_i;
   assign wr_way_c = raw_hit_c ? raw_way_c : (free_any_c ? free_way_c : victim_c);

   // Tag/payload storage is never cleared, so it carries no reset
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         tag_mem[bus.idx][wr_way_c] <= bus.tag;
         pay_mem[bus.idx][wr_way_c] <= bus.payload_i;
      end
   end

   // Valid bits: flush clears one set per cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (clr_c) begin
         valid_q[cnt_q] <= '0;
      end else if (wr_en_c) begin
         valid_q[bus.idx][wr_way_c] <= 1'b1;
      end
   end

`ifdef TAG_RAM_PLRU_EN
   logic [PLRU_W-1:0] repl_q [SETS];
   logic              rd_hit_c;
   logic [WAY_W-1:0]  acc_way_c;

   // Walk from the root; a 0 bit steers to the lower half
   function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
      int unsigned      node;
      logic             b;
      logic [WAY_W-1:0] way;
      node = 0;
      way  = '0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         b                = bits[node];
         way[WAY_W-1-l]   = b;
         node             = 2 * node + 1 + 32'(b);
      end
      return way;
   endfunction

   // Point every node on the accessed way's path away from it
   function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                    input logic [WAY_W-1:0]  way);
      int unsigned       node;
      logic              b;
      logic [PLRU_W-1:0] r;
      r    = bits;
      node = 0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         b       = way[WAY_W-1-l];
         r[node] = ~b;
         node    = 2 * node + 1 + 32'(b);
      end
      return r;
   endfunction

   assign victim_c  = plru_victim(repl_q[bus.idx]);
   assign rd_hit_c  = bus.valid_i && !bus.we && hit_c && !bus.flush_i;
   assign acc_way_c = wr_en_c ? wr_way_c : raw_way_c;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned s = 0; s < SETS; s++) repl_q[s] <= '0;
      end else if (clr_c) begin
         repl_q[cnt_q] <= '0;
      end else if (wr_en_c || rd_hit_c) begin
         repl_q[bus.idx] <= plru_touch(repl_q[bus.idx], acc_way_c);
      end
   end
`else
   logic [WAY_W-1:0] repl_q [SETS];

   assign victim_c = repl_q[bus.idx];

   // Pointer advances only when a valid way is evicted
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned s = 0; s < SETS; s++) repl_q[s] <= '0;
      end else if (clr_c) begin
         repl_q[cnt_q] <= '0;
      end else if (wr_en_c && !raw_hit_c && !free_any_c) begin
         repl_q[bus.idx] <= repl_q[bus.idx] + WAY_W'(1);
      end
   end
`endif

endmodule
